// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating bubble counter.
// Reset is synchronous active-high; a bubble and the reset state are both all-zero.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm_ext,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic [3:0]        id_alu_op,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm_ext,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_alu_src,
  output logic              ex_reg_dst,
  output logic [3:0]        ex_alu_op,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm_ext;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              alu_src;
    logic              reg_dst;
    logic [3:0]        alu_op;
  } ex_t;

  ex_t              ex_q, ex_d, id_bundle;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bubble;

  assign id_bundle = '{
    valid:      id_valid,
    pc4:        id_pc4,
    rs_data:    id_rs_data,
    rt_data:    id_rt_data,
    imm_ext:    id_imm_ext,
    rs:         id_rs,
    rt:         id_rt,
    rd:         id_rd,
    reg_write:  id_reg_write,
    mem_read:   id_mem_read,
    mem_write:  id_mem_write,
    mem_to_reg: id_mem_to_reg,
    alu_src:    id_alu_src,
    reg_dst:    id_reg_dst,
    alu_op:     id_alu_op
  };

  // Load-use check looks only at the registered EX contents and the decode inputs,
  // so the stall/flush controls can never feed back into it.
  assign hazard_stall = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rt != 5'd0) &
                        ((ex_q.rt == id_rs) | (ex_q.rt == id_rt));

  // Priority: flush > external stall > hazard bubble > load.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    ex_d   = ex_q;
    cnt_d  = cnt_q;
    bubble = 1'b0;
    if (flush_in) begin
      bubble = 1'b1;
    end else if (stall_in) begin
      bubble = 1'b0;
    end else if (hazard_stall) begin
      bubble = 1'b1;
    end else begin
      ex_d = id_bundle;
    end
    if (bubble) begin
      ex_d  = '0;
      cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update together.
    if (Reset) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_pc4        = ex_q.pc4;
  assign ex_rs_data    = ex_q.rs_data;
  assign ex_rt_data    = ex_q.rt_data;
  assign ex_imm_ext    = ex_q.imm_ext;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_reg_dst    = ex_q.reg_dst;
  assign ex_alu_op     = ex_q.alu_op;
  assign bubble_cnt    = cnt_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32: width of PC, register-operand and extended-immediate fields.
REQ-002 Parameter CNT_W, default 16: width of the bubble counter.
REQ-003 Clk  in  1: the single clock; all state updates on its rising edge.
REQ-004 Reset  in  1: synchronous, active-high reset.
REQ-005 stall_in  in  1: external hold; all stage registers keep their current values.
REQ-006 flush_in  in  1: squash; the next stage contents become a bubble.
REQ-007 id_valid  in  1: the decode stage holds a real instruction.
REQ-008 id_pc4, id_rs_data, id_rt_data, id_imm_ext  in  DATA_W each: PC+4, the two register-file reads, and the 32-bit sign-extended immediate.
REQ-009 id_rs, id_rt, id_rd  in  5 each: register specifiers.
REQ-010 id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst  in  1 each: decode control bits.
REQ-011 id_alu_op  in  4: ALU operation code.
REQ-012 ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm_ext, ex_rs, ex_rt, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst, ex_alu_op  out  same widths: registered copies of the id_* fields.
REQ-013 hazard_stall  out  1: combinational load-use hazard request to the fetch and decode stages.
REQ-014 bubble_cnt  out  CNT_W: registered count of bubbles inserted.

Function
REQ-015 hazard_stall SHALL equal id_valid & ex_valid & ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
REQ-016 Per-edge priority SHALL be: Reset > flush_in > stall_in > hazard_stall > load.
REQ-017 Load: when no higher-priority condition is active, every ex_* field SHALL take its id_* value on the edge, with ex_valid = id_valid; the latency is 1 cycle.
REQ-018 Bubble: on flush_in, or on hazard_stall with stall_in low, ex_valid, all control outputs, ex_alu_op and all data and specifier fields SHALL become 0.
REQ-019 Hold: when stall_in is high and flush_in is low, all ex_* fields and bubble_cnt SHALL keep their values, regardless of hazard_stall.
REQ-020 bubble_cnt SHALL increment by 1 on each edge where a bubble from REQ-018 is written, whether caused by flush or by hazard, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-021 When id_valid=0 and the stage loads, control bits SHALL still load from the id_* inputs and downstream logic SHALL qualify them with ex_valid; only a bubble forces the control bits to 0.
REQ-022 hazard_stall SHALL depend only on current register state and id_* inputs, and SHALL NOT depend on stall_in or flush_in.
REQ-023 A load that leaves an ex_* field at the same value it already holds SHALL NOT produce any other side effect.

Reset
REQ-024 On a Clk edge with Reset=1, all ex_* outputs SHALL become 0 and bubble_cnt SHALL become 0, regardless of the other inputs.
REQ-025 Reset asserted mid-hazard SHALL clear ex_mem_read, which drops hazard_stall in the following cycle.
REQ-026 Reset SHALL have no effect between clock edges.

Verification
REQ-027 Reset=1 for 2 cycles, then 0 with an idle input -> all outputs are 0 and bubble_cnt=0.
REQ-028 id_valid=1, id_imm_ext=32'hFFFF8000, id_rt_data=32'h0000_0007, id_alu_op=4'h2, no stall or flush -> on the next edge ex_imm_ext=32'hFFFF8000, ex_rt_data=7, ex_alu_op=2, ex_valid=1.
REQ-029 ex holds a lw with ex_mem_read=1 and ex_rt=5, ex_valid=1; decode presents id_rs=5, id_valid=1 -> hazard_stall=1 in the same cycle, the next edge writes a bubble (ex_valid=0, ex_mem_read=0), bubble_cnt goes from 0 to 1, hazard_stall=0 afterwards, and the following edge loads the held instruction.
REQ-030 Same as REQ-029 but with ex_rt=0 and id_rs=0 -> hazard_stall=0 and the instruction loads.
REQ-031 stall_in=1 and flush_in=1 on the same edge -> a bubble is written and bubble_cnt increments; stall_in=1 alone for 3 cycles with changing id_* inputs -> ex_* and bubble_cnt are unchanged.
REQ-032 Force 65535 bubbles with CNT_W=16, then flush once more -> bubble_cnt stays at 16'hFFFF.
